// File: rtl/pps_pkg.sv
// Shared definitions for the multi-rate PPS timer: default rate table,
// capture-register actions and the select-width helper.
package pps_pkg;

   localparam int DEFAULT_NUM_RATES = 4;
   localparam int DEFAULT_ACC_WIDTH = 32;

   // Entry i lives at bits [i*ACC_WIDTH +: ACC_WIDTH]; entry 0 is the rightmost word.
   localparam logic [DEFAULT_NUM_RATES*DEFAULT_ACC_WIDTH-1:0] DEFAULT_RATE_TABLE =
      {32'hd556ced2, 32'hd5564303, 32'hd555b733, 32'hd5555555};

   typedef enum logic [1:0] {
      CAP_IDLE,
      CAP_LOAD,
      CAP_DROP,
      CAP_RELEASE
   } cap_action_e;

   // Bits needed to index n entries; at least 1 so a 1-bit port always exists.
   function automatic int sel_width(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/pps_capture.sv
// PPS input timestamp capture: 2-flop synchroniser, rising-edge detect,
// single-entry holding register with valid/ready handshake and sticky overrun.
module pps_capture
   import pps_pkg::*;
#(
   parameter int TS_WIDTH = 64
) (
   input  logic                clk_pps,
   input  logic                reset_pps_n,
   input  logic                pps_in,
   input  logic [TS_WIDTH-1:0] ts,
   input  logic                cap_ready,
   input  logic                clear_overrun,
   output logic [TS_WIDTH-1:0] cap_ts,
   output logic                cap_valid,
   output logic                cap_overrun
);

   logic [1:0]          sync_q, sync_d;
   logic                pps_prev_q, pps_prev_d;
   logic                edge_q, edge_d;
   logic [TS_WIDTH-1:0] cap_ts_q, cap_ts_d;
   logic                cap_valid_q, cap_valid_d;
   logic                cap_overrun_q, cap_overrun_d;
   cap_action_e         action;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      sync_d        = {sync_q[0], pps_in};
      pps_prev_d    = sync_q[1];
      edge_d        = sync_q[1] & ~pps_prev_q;
      action        = CAP_IDLE;
      cap_ts_d      = cap_ts_q;
      cap_valid_d   = cap_valid_q;

      if (edge_q) begin
         action = (cap_valid_q && !cap_ready) ? CAP_DROP : CAP_LOAD;
      end else if (cap_valid_q && cap_ready) begin
         action = CAP_RELEASE;
      end

      case (action)
         CAP_LOAD: begin
            cap_ts_d    = ts;
            cap_valid_d = 1'b1;
         end
         CAP_RELEASE: cap_valid_d = 1'b0;
         default: ;
      endcase

      // A drop in the same cycle as a clear must leave the flag set.
      cap_overrun_d = (action == CAP_DROP) | (cap_overrun_q & ~clear_overrun);
   end

   always_ff @(posedge clk_pps or negedge reset_pps_n) begin
      if (!reset_pps_n) begin
         sync_q        <= '0;
         pps_prev_q    <= 1'b0;
         edge_q        <= 1'b0;
         // NOTE: the data register is reset as well, because every output must read 0 in reset.
         cap_ts_q      <= '0;
         cap_valid_q   <= 1'b0;
         cap_overrun_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         sync_q        <= sync_d;
         pps_prev_q    <= pps_prev_d;
         edge_q        <= edge_d;
         cap_ts_q      <= cap_ts_d;
         cap_valid_q   <= cap_valid_d;
         cap_overrun_q <= cap_overrun_d;
      end
   end

   assign cap_ts      = cap_ts_q;
   assign cap_valid   = cap_valid_q;
   assign cap_overrun = cap_overrun_q;

endmodule

// File: rtl/pps_timer_multi.sv
// Multi-rate PPS timer: phase accumulator tick, wide timestamp, periodic
// pulse generator and PPS-input timestamp capture.
module pps_timer_multi
   import pps_pkg::*;
#(
   parameter int                                TS_WIDTH           = 64,
   parameter int                                TIME_INCR_VAL      = 20,
   parameter int                                ACC_WIDTH          = 32,
   parameter int                                NUM_RATES          = 4,
   parameter logic [NUM_RATES*ACC_WIDTH-1:0]    RATE_TABLE         = DEFAULT_RATE_TABLE,
   parameter int                                RESET_SEL          = 0,
   parameter int                                PULSE_PERIOD_TICKS = 50000,
   parameter int                                PULSE_WIDTH_TICKS  = 25000,
   localparam int                               SEL_W              = sel_width(NUM_RATES),
   localparam int                               PC_W               = sel_width(PULSE_PERIOD_TICKS)
) (
   input  logic                clk_pps,
   input  logic                reset_pps_n,
   input  logic                rate_step,
   input  logic                pps_in,
   input  logic                cap_ready,
   input  logic                clear_overrun,
   output logic [SEL_W-1:0]    rate_sel,
   output logic                tick,
   output logic                ts_msb,
   output logic                pulse_out,
   output logic [TS_WIDTH-1:0] cap_ts,
   output logic                cap_valid,
   output logic                cap_overrun
);

   localparam logic [TS_WIDTH-1:0] TS_INCR   = TS_WIDTH'(TIME_INCR_VAL);
   localparam logic [SEL_W-1:0]    SEL_LAST  = SEL_W'(NUM_RATES - 1);
   localparam logic [SEL_W-1:0]    SEL_RESET = SEL_W'(RESET_SEL);
   localparam logic [PC_W-1:0]     PC_LAST   = PC_W'(PULSE_PERIOD_TICKS - 1);
   localparam logic [PC_W-1:0]     PC_HIGH   = PC_W'(PULSE_WIDTH_TICKS);

   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [ACC_WIDTH-1:0] rate_inc;
   logic                 tick_q, tick_d;
   logic [TS_WIDTH-1:0]  ts_q, ts_d;
   logic [PC_W-1:0]      pc_q, pc_d;
   logic                 pulse_q, pulse_d;
   logic [SEL_W-1:0]     rate_sel_q, rate_sel_d;

   always_comb begin
      rate_inc        = RATE_TABLE[int'(rate_sel_q)*ACC_WIDTH +: ACC_WIDTH];
      // The carry out of the wrap-around add is the next tick.
      {tick_d, acc_d} = {1'b0, acc_q} + {1'b0, rate_inc};

      // acc keeps its phase across a rate change.
      rate_sel_d = rate_sel_q;
      if (rate_step) begin
         rate_sel_d = (rate_sel_q == SEL_LAST) ? '0 : rate_sel_q + 1'b1;
      end

      ts_d    = ts_q;
      pc_d    = pc_q;
      pulse_d = pulse_q;
      if (tick_q) begin
         ts_d    = ts_q + TS_INCR;
         pulse_d = (pc_q < PC_HIGH);
         pc_d    = (pc_q == PC_LAST) ? '0 : pc_q + 1'b1;
      end
   end

   always_ff @(posedge clk_pps or negedge reset_pps_n) begin
      if (!reset_pps_n) begin
         acc_q      <= '0;
         tick_q     <= 1'b0;
         ts_q       <= '0;
         pc_q       <= '0;
         pulse_q    <= 1'b0;
         rate_sel_q <= SEL_RESET;
      end else begin
         acc_q      <= acc_d;
         tick_q     <= tick_d;
         ts_q       <= ts_d;
         pc_q       <= pc_d;
         pulse_q    <= pulse_d;
         rate_sel_q <= rate_sel_d;
      end
   end

   pps_capture #(
      .TS_WIDTH (TS_WIDTH)
   ) u_capture (
      .clk_pps       (clk_pps),
      .reset_pps_n   (reset_pps_n),
      .pps_in        (pps_in),
      .ts            (ts_q),
      .cap_ready     (cap_ready),
      .clear_overrun (clear_overrun),
      .cap_ts        (cap_ts),
      .cap_valid     (cap_valid),
      .cap_overrun   (cap_overrun)
   );

   assign rate_sel  = rate_sel_q;
   assign tick      = tick_q;
   assign ts_msb    = ts_q[TS_WIDTH-1];
   assign pulse_out = pulse_q;

endmodule

// File: tb/tb_pps_timer_multi.sv
// Scoreboard bench for pps_timer_multi: directed scenarios then random stimulus,
// checked against a tick-count based reference model.
module tb_pps_timer_multi;

   localparam int                  TS_W  = 12;
   localparam int                  INCR  = 20;
   localparam int                  AW    = 4;
   localparam int                  NR    = 4;
   localparam logic [NR*AW-1:0]    TABLE = {4'hC, 4'h4, 4'h8, 4'h0};
   localparam int                  RSEL  = 1;
   localparam int                  PER   = 4;
   localparam int                  WID   = 1;

   logic            clk_pps       = 1'b0;
   logic            reset_pps_n   = 1'b1;
   logic            rate_step     = 1'b0;
   logic            pps_in        = 1'b0;
   logic            cap_ready     = 1'b0;
   logic            clear_overrun = 1'b0;
   logic [1:0]      rate_sel;
   logic            tick;
   logic            ts_msb;
   logic            pulse_out;
   logic [TS_W-1:0] cap_ts;
   logic            cap_valid;
   logic            cap_overrun;

   pps_timer_multi #(
      .TS_WIDTH           (TS_W),
      .TIME_INCR_VAL      (INCR),
      .ACC_WIDTH          (AW),
      .NUM_RATES          (NR),
      .RATE_TABLE         (TABLE),
      .RESET_SEL          (RSEL),
      .PULSE_PERIOD_TICKS (PER),
      .PULSE_WIDTH_TICKS  (WID)
   ) dut (
      .clk_pps       (clk_pps),
      .reset_pps_n   (reset_pps_n),
      .rate_step     (rate_step),
      .pps_in        (pps_in),
      .cap_ready     (cap_ready),
      .clear_overrun (clear_overrun),
      .rate_sel      (rate_sel),
      .tick          (tick),
      .ts_msb        (ts_msb),
      .pulse_out     (pulse_out),
      .cap_ts        (cap_ts),
      .cap_valid     (cap_valid),
      .cap_overrun   (cap_overrun)
   );

   always #5 clk_pps = ~clk_pps;

   // ---------------- reference model ----------------
   int unsigned     m_acc, m_sum, m_ticks, m_sel;
   logic            m_tick, m_pulse, m_valid, m_ovr, m_prev_pin, m_edge, m_drop;
   logic [TS_W-1:0] m_ts;
   longint unsigned m_cyc;
   longint unsigned rise_at[$];
   logic [TS_W-1:0] sb_q[$];

   int n_checks = 0;
   int n_errors = 0;
   logic end_req = 1'b0;
   logic end_done = 1'b0;

   function automatic int unsigned rate_of(input int unsigned sel);
      logic [NR*AW-1:0] t;
      t = TABLE;
      return int'(t[sel*AW +: AW]);
   endfunction

   always @(posedge clk_pps or negedge reset_pps_n) begin
      if (!reset_pps_n) begin
         m_acc = 0; m_ticks = 0; m_ts = '0; m_tick = 0; m_pulse = 0;
         m_sel = RSEL; m_valid = 0; m_ovr = 0; m_prev_pin = 0; m_cyc = 0;
         rise_at.delete();
         sb_q.delete();
      end else begin
         m_cyc++;
         // A rise sampled at edge n is loaded into the holding register at edge n+3.
         m_edge = (rise_at.size() > 0) && (rise_at[0] == m_cyc);
         if (m_edge) void'(rise_at.pop_front());
         if (pps_in && !m_prev_pin) rise_at.push_back(m_cyc + 3);
         m_prev_pin = pps_in;

         m_drop = 1'b0;
         if (m_edge) begin
            if (m_valid && !cap_ready) m_drop = 1'b1;
            else begin
               m_valid = 1'b1;
               sb_q.push_back(m_ts);
            end
         end else if (m_valid && cap_ready) begin
            m_valid = 1'b0;
         end
         m_ovr = m_drop | (m_ovr & ~clear_overrun);

         if (m_tick) begin
            m_ticks++;
            m_ts    = TS_W'((m_ticks * INCR) % (1 << TS_W));
            m_pulse = (((m_ticks - 1) % PER) < WID);
         end
         m_sum  = m_acc + rate_of(m_sel);
         m_tick = (m_sum >= (1 << AW));
         m_acc  = m_sum % (1 << AW);
         if (rate_step) m_sel = (m_sel + 1) % NR;
      end
   end

   // ---------------- monitor / checker ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk_pps or negedge reset_pps_n);
         if (!reset_pps_n) begin
            #1;
            check("rst_rate_sel", rate_sel, RSEL);
            check("rst_tick", tick, 0);
            check("rst_ts_msb", ts_msb, 0);
            check("rst_pulse_out", pulse_out, 0);
            check("rst_cap_ts", cap_ts, 0);
            check("rst_cap_valid", cap_valid, 0);
            check("rst_cap_overrun", cap_overrun, 0);
         end else begin
            check("rate_sel", rate_sel, m_sel);
            check("tick", tick, m_tick);
            check("ts_msb", ts_msb, m_ts[TS_W-1]);
            check("pulse_out", pulse_out, m_pulse);
            check("cap_valid", cap_valid, m_valid);
            check("cap_overrun", cap_overrun, m_ovr);
            if (cap_valid && cap_ready) begin
               if (sb_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL cap_ts_unexpected @%0t: got 0x%0h, expected no transfer", $time, cap_ts);
               end else begin
                  check("cap_ts", cap_ts, sb_q.pop_front());
               end
            end
            if (end_req && !end_done) begin
               end_done = 1'b1;
               check("pending_vs_valid", cap_valid, (sb_q.size() == 1));
               if (sb_q.size() == 1) check("pending_cap_ts", cap_ts, sb_q[0]);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_pps);
         #1;
      end
   endtask

   task automatic pps_pulse(input int hi, input int lo);
      pps_in = 1'b1;
      step(hi);
      pps_in = 1'b0;
      step(lo);
   endtask

   task automatic do_rate_step();
      rate_step = 1'b1;
      step(1);
      rate_step = 1'b0;
      step(1);
   endtask

   initial begin
      #2 reset_pps_n = 1'b0;
      step(3);
      reset_pps_n = 1'b1;
      step(25);

      // held capture, then a dropped edge, then clear
      cap_ready = 1'b0;
      pps_pulse(6, 4);
      pps_pulse(6, 4);
      clear_overrun = 1'b1;
      step(1);
      clear_overrun = 1'b0;
      step(2);

      // new edge in the same cycle as the handshake
      pps_in = 1'b1;
      step(3);
      cap_ready = 1'b1;
      step(1);
      cap_ready = 1'b0;
      step(3);
      pps_in = 1'b0;
      step(3);
      cap_ready = 1'b1;
      step(2);
      cap_ready = 1'b0;

      // rate table walk including wrap and the stopped entry
      do_rate_step();
      step(16);
      do_rate_step();
      step(12);
      do_rate_step();
      step(8);
      cap_ready = 1'b1;
      pps_pulse(6, 10);
      cap_ready = 1'b0;
      do_rate_step();
      step(10);

      // asynchronous reset with a capture pending
      pps_pulse(6, 4);
      #2 reset_pps_n = 1'b0;
      step(3);
      reset_pps_n = 1'b1;
      step(5);

      for (int i = 0; i < 4000; i++) begin
         if (i == 2500) begin
            #2 reset_pps_n = 1'b0;
            step(2);
            reset_pps_n = 1'b1;
         end
         if ($urandom_range(0, 19) == 0) pps_in = ~pps_in;
         cap_ready     = 1'($urandom_range(0, 1));
         rate_step     = ($urandom_range(0, 59) == 0);
         clear_overrun = ($urandom_range(0, 29) == 0);
         step(1);
      end

      pps_in = 1'b0;
      cap_ready = 1'b0;
      rate_step = 1'b0;
      clear_overrun = 1'b0;
      step(8);
      end_req = 1'b1;
      step(3);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
